// File: rtl/interface_demux.sv
// interface_demux: replicates backend frames into the tx data/ptr FIFOs of the ports in the descriptor mask.
module interface_demux #(
  parameter int MAX_LEN    = 1536,
  parameter int DROP_CNT_W = 16
) (
  input  logic                  clk_sys,
  input  logic                  rst_sys,
  output logic                  sfifo_rd,
  input  logic [7:0]            sfifo_dout,
  output logic                  ptr_sfifo_rd,
  input  logic [15:0]           ptr_sfifo_dout,
  input  logic                  ptr_sfifo_empty,
  output logic [3:0]            tx_data_fifo_wr,
  output logic [7:0]            tx_data_fifo_din,
  input  logic [3:0]            tx_data_fifo_afull,
  output logic [3:0]            tx_ptr_fifo_wr,
  output logic [15:0]           tx_ptr_fifo_din,
  input  logic [3:0]            tx_ptr_fifo_full,
  output logic [DROP_CNT_W-1:0] drop_cnt
);
  typedef enum logic [2:0] {IDLE, PTR_RD, PTR_CAP, CHECK, DATA, FLUSH, PTR_WR} state_t;
  localparam logic [11:0] MAX_L = 12'(MAX_LEN);
  state_t st, nxt;
  logic [10:0] len, cnt;
  logic [3:0] mask;
  logic drop, fl, rd_d1, cap_drop, ptr_wr_en;
  assign cap_drop = ptr_sfifo_dout[15] | (ptr_sfifo_dout[14:11] == 4'd0) |
                    (ptr_sfifo_dout[10:0] == 11'd0) | ({1'b0, ptr_sfifo_dout[10:0]} > MAX_L);
  assign ptr_wr_en = (nxt == PTR_WR) && !drop;
  always_comb begin
    nxt = st;
    case (st)
      IDLE:    nxt = ptr_sfifo_empty ? IDLE : PTR_RD;
      PTR_RD:  nxt = PTR_CAP;
      PTR_CAP: nxt = CHECK;
      CHECK:   nxt = drop ? ((len == 11'd0) ? PTR_WR : DATA) :
                     ((mask & (tx_data_fifo_afull | tx_ptr_fifo_full)) == 4'd0) ? DATA : CHECK;
      DATA:    nxt = (cnt == 11'd1) ? FLUSH : DATA;
      FLUSH:   nxt = fl ? PTR_WR : FLUSH;
      PTR_WR:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      st               <= IDLE;
      sfifo_rd         <= 1'b0;
      ptr_sfifo_rd     <= 1'b0;
      tx_data_fifo_wr  <= '0;
      tx_data_fifo_din <= '0;
      tx_ptr_fifo_wr   <= '0;
      tx_ptr_fifo_din  <= '0;
      drop_cnt         <= '0;
      len              <= '0;
      cnt              <= '0;
      mask             <= '0;
      drop             <= 1'b0;
      fl               <= 1'b0;
      rd_d1            <= 1'b0;
    end else begin
      st               <= nxt;
      ptr_sfifo_rd     <= nxt == PTR_RD;
      sfifo_rd         <= nxt == DATA;
      rd_d1            <= sfifo_rd;
      tx_data_fifo_wr  <= (rd_d1 && !drop) ? mask : 4'd0;
      tx_data_fifo_din <= sfifo_dout;
      tx_ptr_fifo_wr   <= ptr_wr_en ? mask : 4'd0;
      tx_ptr_fifo_din  <= ptr_wr_en ? {5'b0, len} : 16'd0;
      drop_cnt         <= ((nxt == PTR_WR) && drop && !(&drop_cnt)) ? drop_cnt + 1'b1 : drop_cnt;
      fl               <= (st == FLUSH) && !fl;
      if (st == PTR_CAP) begin
        len  <= ptr_sfifo_dout[10:0];
        cnt  <= ptr_sfifo_dout[10:0];
        mask <= ptr_sfifo_dout[14:11];
        drop <= cap_drop;
      end else if (st == DATA) begin
        cnt <= cnt - 11'd1;
      end
    end
  end
endmodule

// File: tb/tb_interface_demux.sv
// tb_interface_demux: directed steps with a backend FIFO model and a tx-side scoreboard.
module tb_interface_demux;
  logic        clk_sys = 1'b0;
  logic        rst_sys = 1'b1;
  logic        sfifo_rd, ptr_sfifo_rd;
  logic [7:0]  sfifo_dout = 8'd0;
  logic [15:0] ptr_sfifo_dout = 16'd0;
  logic        ptr_sfifo_empty = 1'b1;
  logic [3:0]  tx_data_fifo_wr, tx_ptr_fifo_wr;
  logic [7:0]  tx_data_fifo_din;
  logic [15:0] tx_ptr_fifo_din;
  logic [3:0]  tx_data_fifo_afull = 4'd0;
  logic [3:0]  tx_ptr_fifo_full = 4'd0;
  logic [15:0] drop_cnt;

  interface_demux #(.MAX_LEN(1536), .DROP_CNT_W(16)) dut (
    .clk_sys(clk_sys), .rst_sys(rst_sys),
    .sfifo_rd(sfifo_rd), .sfifo_dout(sfifo_dout),
    .ptr_sfifo_rd(ptr_sfifo_rd), .ptr_sfifo_dout(ptr_sfifo_dout), .ptr_sfifo_empty(ptr_sfifo_empty),
    .tx_data_fifo_wr(tx_data_fifo_wr), .tx_data_fifo_din(tx_data_fifo_din),
    .tx_data_fifo_afull(tx_data_fifo_afull),
    .tx_ptr_fifo_wr(tx_ptr_fifo_wr), .tx_ptr_fifo_din(tx_ptr_fifo_din),
    .tx_ptr_fifo_full(tx_ptr_fifo_full),
    .drop_cnt(drop_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  logic [7:0]  dq[$];
  logic [15:0] pq[$];
  logic [11:0] exp_d[$];
  logic [19:0] exp_p[$];
  int n_cmp = 0, n_err = 0;
  int cyc = 0, rd_cnt = 0, last_rd = 0, rd_gap = 0, run = 0, last_wr_cyc = 0, quiet = 0;
  logic prev_rd = 1'b0, prev_wr = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Backend FIFOs: read data appears one cycle after the read enable.
  always @(posedge clk_sys) begin
    if (rst_sys) begin
      dq.delete();
      pq.delete();
    end else begin
      if (sfifo_rd) sfifo_dout <= (dq.size() > 0) ? dq.pop_front() : 8'hEE;
      if (ptr_sfifo_rd) ptr_sfifo_dout <= (pq.size() > 0) ? pq.pop_front() : 16'h0;
    end
  end

  always @(negedge clk_sys) begin
    logic [19:0] e;
    ptr_sfifo_empty = (pq.size() == 0);
    cyc++;
    if (sfifo_rd) begin
      rd_cnt++;
      if (!prev_rd) rd_gap = cyc - last_rd;
      last_rd = cyc;
    end
    prev_rd = sfifo_rd;
    if (|tx_ptr_fifo_wr) begin
      e = (exp_p.size() > 0) ? exp_p.pop_front() : 20'd0;
      chk("ptr", 32'({tx_ptr_fifo_wr, tx_ptr_fifo_din}), 32'(e));
      chk("ptr_run_len", 32'(run), 32'(e[10:0]));
      chk("ptr_lag", 32'(cyc - last_wr_cyc), 32'd1);
    end
    if (|tx_data_fifo_wr) begin
      run = prev_wr ? run + 1 : 1;
      last_wr_cyc = cyc;
      chk("data", 32'({tx_data_fifo_wr, tx_data_fifo_din}),
          (exp_d.size() > 0) ? 32'(exp_d.pop_front()) : 32'd0);
    end
    prev_wr = |tx_data_fifo_wr;
    quiet = (sfifo_rd | ptr_sfifo_rd | (|tx_data_fifo_wr) | (|tx_ptr_fifo_wr)) ? 0 : quiet + 1;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk_sys);
      #1;
    end
  endtask

  task automatic push_frame(input logic [15:0] p, input logic [7:0] base);
    logic [10:0] len;
    logic [3:0]  mask;
    logic        drop;
    logic [7:0]  b;
    len  = p[10:0];
    mask = p[14:11];
    drop = p[15] || mask == 4'd0 || len == 11'd0 || len > 11'd1536;
    for (int i = 0; i < int'(len); i++) begin
      b = base + 8'(i);
      dq.push_back(b);
      if (!drop) exp_d.push_back({mask, b});
    end
    if (!drop) exp_p.push_back({mask, 5'b0, len});
    pq.push_back(p);
  endtask

  task automatic wait_quiet(input string tag, input int budget);
    int n;
    logic done;
    n = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      tick(1);
      n++;
      done = (quiet >= 12) && (pq.size() == 0);
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_rd"}, 32'({sfifo_rd, ptr_sfifo_rd}), 32'd0);
    chk({tag, "_tx_data"}, 32'({tx_data_fifo_wr, tx_data_fifo_din}), 32'd0);
    chk({tag, "_tx_ptr"}, 32'({tx_ptr_fifo_wr, tx_ptr_fifo_din}), 32'd0);
    chk({tag, "_drop_cnt"}, 32'(drop_cnt), 32'd0);
  endtask

  initial begin
    int r0;
    int n;
    tick(3);
    chk_outputs_zero("reset");
    rst_sys = 1'b0;
    tick(2);

    // Unicast to port 2 while an unselected port is almost full
    tx_data_fifo_afull = 4'b1000;
    r0 = rd_cnt;
    push_frame(16'h2040, 8'h00);
    wait_quiet("uni_done", 300);
    chk("uni_reads", 32'(rd_cnt - r0), 32'd64);
    chk("uni_sb_empty", 32'(exp_d.size() + exp_p.size()), 32'd0);
    chk("uni_drop_cnt", 32'(drop_cnt), 32'd0);
    tx_data_fifo_afull = 4'b0000;

    // Broadcast held off by one almost-full port
    tx_data_fifo_afull = 4'b0010;
    r0 = rd_cnt;
    push_frame(16'h783C, 8'h40);
    tick(20);
    chk("bc_hold_reads", 32'(rd_cnt - r0), 32'd0);
    chk("bc_hold_pending", 32'(exp_d.size()), 32'd60);
    tx_data_fifo_afull = 4'b0000;
    wait_quiet("bc_done", 300);
    chk("bc_reads", 32'(rd_cnt - r0), 32'd60);
    chk("bc_sb_empty", 32'(exp_d.size() + exp_p.size()), 32'd0);

    // Drops: error flag, empty mask, zero length
    r0 = rd_cnt;
    push_frame(16'hA040, 8'h80);
    wait_quiet("drop_err_done", 300);
    chk("drop_err_reads", 32'(rd_cnt - r0), 32'd64);
    chk("drop_err_cnt", 32'(drop_cnt), 32'd1);
    r0 = rd_cnt;
    push_frame(16'h0010, 8'h70);
    wait_quiet("drop_mask_done", 300);
    chk("drop_mask_reads", 32'(rd_cnt - r0), 32'd16);
    chk("drop_mask_cnt", 32'(drop_cnt), 32'd2);
    r0 = rd_cnt;
    push_frame(16'h2000, 8'h00);
    wait_quiet("drop_len0_done", 300);
    chk("drop_len0_reads", 32'(rd_cnt - r0), 32'd0);
    chk("drop_len0_cnt", 32'(drop_cnt), 32'd3);

    // Oversize frame drained, then a short frame must arrive intact
    r0 = rd_cnt;
    push_frame(16'h0FFF, 8'h11);
    push_frame(16'h0808, 8'h5A);
    wait_quiet("oversize_done", 3000);
    chk("oversize_reads", 32'(rd_cnt - r0), 32'd2055);
    chk("oversize_cnt", 32'(drop_cnt), 32'd4);
    chk("oversize_sb_empty", 32'(exp_d.size() + exp_p.size()), 32'd0);

    // Back-to-back frames: IDLE..CHECK plus FLUSH x2 and PTR_WR sit between read bursts
    r0 = rd_cnt;
    push_frame(16'h0840, 8'h10);
    push_frame(16'h1080, 8'h90);
    wait_quiet("b2b_done", 600);
    chk("b2b_reads", 32'(rd_cnt - r0), 32'd192);
    chk("b2b_idle_between_reads", 32'(rd_gap - 1), 32'd7);
    chk("b2b_sb_empty", 32'(exp_d.size() + exp_p.size()), 32'd0);

    // Reset on the 10th byte read, then a clean frame
    r0 = rd_cnt;
    push_frame(16'h2040, 8'h33);
    n = 0;
    while (rd_cnt != r0 + 10 && n < 200) begin
      tick(1);
      n++;
    end
    chk("rst_reached_byte10", 32'(rd_cnt - r0), 32'd10);
    rst_sys = 1'b1;
    tick(1);
    chk_outputs_zero("mid_rst");
    rst_sys = 1'b0;
    exp_d.delete();
    exp_p.delete();
    tick(2);
    r0 = rd_cnt;
    push_frame(16'h1020, 8'hC0);
    wait_quiet("post_rst_done", 300);
    chk("post_rst_reads", 32'(rd_cnt - r0), 32'd32);
    chk("post_rst_sb_empty", 32'(exp_d.size() + exp_p.size()), 32'd0);
    chk("post_rst_drop_cnt", 32'(drop_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
